mux_7seg_scan_decoder: RTL and testbench

MUX_7SEG_SCAN_DECODER -- requirements
Module: mux_7seg_scan_decoder

---
 rtl/mux_7seg_scan_decoder.sv | 173 +++++++++++++++++
 tb/tb_mux_7seg_scan_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_7seg_scan_decoder.sv
// Recovers the four BCD digits shown on a multiplexed, active-low 7-segment display.
// A digit is captured once its synchronized segment/enable pair has been stable long enough.
module mux_7seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  digit_enable,
  output logic [15:0] digits_bcd,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic        enable_err
);

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned EN_W   = 4;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned PAIR_W = SEG_W + EN_W;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CODE_W = DIG_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STABLE    = CNT_W'(STABLE_CYCLES);
  localparam logic [EN_W-1:0]  MASK_FULL = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  logic [SEG_W-1:0]          seg_s1, seg_s2;
  logic [EN_W-1:0]           en_s1, en_s2;
  logic [PAIR_W-1:0]         pair_c, pair_q;
  logic                      chg_q;
  logic [CNT_W-1:0]          count_q;
  logic [EN_W-1:0]           mask_q;
  state_t                    state_q, state_d;

  logic                      capture_c;
  logic [SEG_W-1:0]          held_seg;
  logic [EN_W-1:0]           held_en;
  logic                      en_idle;
  logic [CODE_W-1:0]         dec;
  logic [EN_W*DIG_W-1:0]     digits_d;
  logic [EN_W-1:0]           valid_d, mask_d;
  logic                      perr_d, eerr_d;

  // {error, code}: unknown patterns map to code E with the error bit set
  function automatic logic [CODE_W-1:0] decode(input logic [SEG_W-1:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  assign pair_c   = {seg_s2, en_s2};
  assign held_seg = pair_q[PAIR_W-1:EN_W];
  assign held_en  = pair_q[EN_W-1:0];
  assign en_idle  = &held_en;

  // Synchronizers, previous-pair register and saturating stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1  <= '0;
      seg_s2  <= '0;
      en_s1   <= '0;
      en_s2   <= '0;
      pair_q  <= '0;
      chg_q   <= 1'b0;
      count_q <= '0;
    end else begin
      seg_s1  <= seg;
      seg_s2  <= seg_s1;
      en_s1   <= digit_enable;
      en_s2   <= en_s1;
      pair_q  <= pair_c;
      chg_q   <= (pair_c != pair_q);
      if (pair_c != pair_q) begin
        count_q <= CNT_W'(1);
      end else if (count_q != CNT_MAX) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // chg_q rather than the counter marks a new pair, so the all-zero post-reset
  // contents of the synchronizers can never start a capture
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (chg_q && !en_idle) state_d = SETTLE;
      end
      SETTLE: begin
        if (en_idle) begin
          state_d = IDLE;
        end else if (count_q == STABLE) begin
          state_d   = HELD;
          capture_c = 1'b1;
        end
      end
      HELD: begin
        if (chg_q) state_d = en_idle ? IDLE : SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture datapath; a full mask is cleared before this edge's capture is merged in
  always_comb begin
    digits_d = digits_bcd;
    valid_d  = digit_valid;
    mask_d   = (mask_q == MASK_FULL) ? '0 : mask_q;
    perr_d   = 1'b0;
    eerr_d   = 1'b0;
    dec      = decode(held_seg);
    if (capture_c) begin
      if ($onehot(~held_en)) begin
        for (int unsigned n = 0; n < EN_W; n++) begin
          if (!held_en[n]) begin
            digits_d[DIG_W*n +: DIG_W] = dec[DIG_W-1:0];
            valid_d[n]                 = 1'b1;
            mask_d[n]                  = 1'b1;
          end
        end
        perr_d = dec[CODE_W-1];
      end else begin
        eerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      digits_bcd  <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      enable_err  <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      digits_bcd  <= digits_d;
      digit_valid <= valid_d;
      frame_valid <= (mask_q == MASK_FULL);
      pattern_err <= perr_d;
      enable_err  <= eerr_d;
    end
  end

endmodule

// File: tb/tb_mux_7seg_scan_decoder.sv
// Bench for mux_7seg_scan_decoder: held pin periods are turned into expected output
// events by a period-level model; a monitor compares every cycle against the queue.
module tb_mux_7seg_scan_decoder;

  localparam int unsigned S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  digit_enable = 4'hF;
  logic [15:0] digits_bcd;
  logic [3:0]  digit_valid;
  logic        frame_valid, pattern_err, enable_err;

  mux_7seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg          (seg),
    .digit_enable (digit_enable),
    .digits_bcd   (digits_bcd),
    .digit_valid  (digit_valid),
    .frame_valid  (frame_valid),
    .pattern_err  (pattern_err),
    .enable_err   (enable_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [22:0] vec;
  } ev_t;

  ev_t  q[$];
  int   checks = 0;
  int   passed = 0;

  logic [6:0]  pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0]  m_dig [4];
  logic [3:0]  m_valid = '0;
  logic [3:0]  m_mask = '0;
  logic [10:0] last_pins = '1;

  function automatic int ref_code(input logic [6:0] s);
    if (s == 7'b1111111) return 15;
    for (int i = 0; i < 10; i++) if (pat[i] == s) return i;
    return 14;
  endfunction

  function automatic logic [22:0] model_vec(input logic fv, input logic pe, input logic ee);
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_valid, fv, pe, ee};
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  // Hold one pin pair for len edges; a long enough period yields one capture at k+2+S
  task automatic drive(input logic [6:0] s, input logic [3:0] e, input int len);
    int  k, c, code, n;
    ev_t ev;
    k = cyc + 1;
    seg = s;
    digit_enable = e;
    last_pins = {s, e};
    if (len >= int'(S) && e != 4'hF) begin
      c = k + 2 + int'(S);
      if ($countones(~e) == 1) begin
        n = 0;
        for (int i = 0; i < 4; i++) if (!e[i]) n = i;
        code = ref_code(s);
        m_dig[n] = 4'(code);
        m_valid[n] = 1'b1;
        m_mask[n] = 1'b1;
        ev.cyc = c; ev.vec = model_vec(1'b0, code == 14, 1'b0);
      end else begin
        ev.cyc = c; ev.vec = model_vec(1'b0, 1'b0, 1'b1);
      end
      q.push_back(ev);
      if (m_mask == 4'hF) begin
        m_mask = '0;
        ev.cyc = c + 1; ev.vec = model_vec(1'b1, 1'b0, 1'b0);
        q.push_back(ev);
      end
    end
    repeat (len) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seg = 7'h7F;
    digit_enable = 4'hF;
    last_pins = '1;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    m_valid = '0;
    m_mask = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Monitor: every cycle is either an expected event or must hold the last state with no pulses
  initial begin
    logic [22:0] act, last;
    ev_t e;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      act = {digits_bcd, digit_valid, frame_valid, pattern_err, enable_err};
      if (!rst_n) begin
        last = '0;
        check("reset", act, 23'h0);
      end else begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          checks++;
          $display("FAIL missed_event cyc=%0d got=%h expected=%h at cyc %0d", cyc, act, e.vec, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          check("event", act, e.vec);
          last = {e.vec[22:3], 3'b000};
        end else begin
          check("steady", act, last);
        end
      end
    end
  end

  initial begin
    logic [6:0] s;
    logic [3:0] e;
    int         r, t;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // scan 1,2,3,4 -> 4321 and one frame pulse
    drive(pat[1], 4'b1110, 20);
    drive(pat[2], 4'b1101, 20);
    drive(pat[3], 4'b1011, 20);
    drive(pat[4], 4'b0111, 20);
    // latency: digit 2 updates exactly S+2 edges after the pins settle
    drive(pat[2], 4'b1011, 20);
    // short blank glitch inside a stable 7
    drive(pat[7], 4'b1101, 20);
    drive(7'h7F,  4'b1101, 2);
    drive(pat[7], 4'b1101, 20);
    // undecodable pattern and double-low enable
    drive(7'b0101010, 4'b1110, 20);
    drive(pat[5], 4'b1100, 20);
    // reset after three captures with the fourth still settling
    drive(7'h7F, 4'hF, 10);
    drive(pat[6], 4'b1110, 20);
    drive(pat[8], 4'b1101, 20);
    drive(pat[9], 4'b1011, 20);
    drive(pat[0], 4'b0111, 2);
    do_reset();
    drive(pat[3], 4'b1110, 20);
    drive(pat[1], 4'b1101, 20);
    drive(pat[4], 4'b1011, 20);
    drive(pat[1], 4'b0111, 20);
    // very long hold: one capture only
    drive(pat[5], 4'b0111, 1000);

    repeat (150) begin
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        e = 4'hF;
        e[$urandom_range(0, 3)] = 1'b0;
      end else if (r <= 8) begin
        e = 4'($urandom_range(0, 15));
        while ($countones(~e) < 2) e = 4'($urandom_range(0, 15));
      end else begin
        e = 4'hF;
      end
      r = $urandom_range(0, 9);
      if (r < 8) s = pat[$urandom_range(0, 9)];
      else if (r == 8) s = 7'h7F;
      else s = 7'($urandom_range(0, 127));
      if ({s, e} == last_pins) s[0] = ~s[0];
      drive(s, e, $urandom_range(1, 3 * int'(S)));
    end
    drive(7'h7F, 4'hF, 4);

    t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
